dma_tx_fe_player: RTL

DMA_TX_FE_PLAYER -- requirements
Module: dma_tx_fe_player

---
 rtl/dma_tx_fe_player.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dma_tx_fe_player.sv
// Purpose: plays timestamped TX bursts from the sample RAM onto a 64-bit word stream.
// Latency: first word 2 cycles after PLAY entry, then 1 word/cycle while m_data_ready is high.
// Backpressure: reads are throttled so buffered plus in-flight words never exceed the 2-entry FIFO.
module dma_tx_fe_player #(
  parameter int TIMESTAMP_BITS = 49,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_BITS      = 3,
  parameter int SAMPLES_WIDTH  = 16,
  parameter int STAT_FE_WIDTH  = 20
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         en,
  input  logic [TIMESTAMP_BITS-2:0]                                    s_ts,
  input  logic                                                         s_descr_valid,
  output logic                                                         s_descr_ready,
  input  logic [TIMESTAMP_BITS+SAMPLES_WIDTH+RAM_ADDR_WIDTH-DATA_BITS-1:0] s_descr_data,
  output logic                                                         m_proc_idx_valid,
  input  logic                                                         m_proc_idx_ready,
  output logic [RAM_ADDR_WIDTH-8:0]                                    m_fedma_ram_addr,
  output logic                                                         m_ram_rden,
  output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]                          m_ram_raddr,
  input  logic [63:0]                                                  m_ram_rdata,
  output logic                                                         m_data_valid,
  input  logic                                                         m_data_ready,
  output logic [63:0]                                                  m_data,
  output logic                                                         m_data_last,
  output logic [SAMPLES_WIDTH-1:0]                                     m_burst_samples,
  output logic [STAT_FE_WIDTH-1:0]                                     stat_late_bursts
);

  localparam int WW = RAM_ADDR_WIDTH - DATA_BITS;            // word address width
  localparam int TW = TIMESTAMP_BITS - 1;                    // timestamp value width
  localparam int DW = TIMESTAMP_BITS + SAMPLES_WIDTH + WW;   // descriptor width
  localparam int FW = RAM_ADDR_WIDTH + 1 - 8;                // 256-byte granular pointer width

  typedef enum logic [2:0] {IDLE, WAIT_TS, PLAY, DRAIN, DONE} state_t;

  state_t          state;
  logic            b_nots;
  logic [TW-1:0]   b_ts;
  logic [WW-1:0]   b_words;
  logic [WW-1:0]   rd_ptr;
  logic [WW:0]     cons_ptr;
  logic [WW-1:0]   reads_left;
  logic [WW-1:0]   beats_left;

  logic            rvld;
  logic [63:0]     fifo_mem [2];
  logic            fifo_wp;
  logic            fifo_rp;
  logic [1:0]      fifo_cnt;

  logic [TW-1:0]   ts_diff;
  logic            pop;
  logic [2:0]      occ;
  logic            rd_ok;
  logic            proc_hs;
  logic [WW:0]     cons_next;

  // Signed distance to the burst start; wraps with the timestamp counter.
  assign ts_diff   = b_ts - s_ts;
  assign m_data_valid = (fifo_cnt != 2'd0);
  assign m_data    = fifo_mem[fifo_rp];
  assign pop       = m_data_valid && m_data_ready;
  assign m_data_last = m_data_valid && (beats_left == WW'(1));
  // Occupancy counts the word still in the RAM pipeline; a same-cycle pop frees one slot.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, rvld};
  assign rd_ok     = (occ < 3'd2) || (pop && (occ == 3'd2));
  assign m_ram_rden  = en && (state == PLAY) && rd_ok;
  assign m_ram_raddr = rd_ptr;
  assign proc_hs   = m_proc_idx_valid && m_proc_idx_ready;
  assign cons_next = cons_ptr + {1'b0, b_words};

  // Read-return pipeline and FIFO pointers; en low discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld     <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (!en) begin
      rvld     <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rvld <= m_ram_rden;
      if (rvld) fifo_wp <= ~fifo_wp;
      if (pop)  fifo_rp <= ~fifo_rp;
      case ({rvld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage captures RAM data the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rvld) fifo_mem[fifo_wp] <= m_ram_rdata;
  end

  // Burst sequencer with registered handshake outputs and pointer bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      b_nots           <= 1'b0;
      b_ts             <= '0;
      b_words          <= '0;
      rd_ptr           <= '0;
      cons_ptr         <= '0;
      reads_left       <= '0;
      beats_left       <= '0;
      s_descr_ready    <= 1'b0;
      m_proc_idx_valid <= 1'b0;
      m_fedma_ram_addr <= '0;
      m_burst_samples  <= '0;
      stat_late_bursts <= '0;
    end else if (!en) begin
      state            <= IDLE;
      b_nots           <= 1'b0;
      b_ts             <= '0;
      b_words          <= '0;
      rd_ptr           <= '0;
      cons_ptr         <= '0;
      reads_left       <= '0;
      beats_left       <= '0;
      s_descr_ready    <= 1'b0;
      m_proc_idx_valid <= 1'b0;
      m_fedma_ram_addr <= '0;
      m_burst_samples  <= '0;
      stat_late_bursts <= '0;
    end else begin
      if (pop) beats_left <= beats_left - WW'(1);
      case (state)
        IDLE: begin
          if (s_descr_ready && s_descr_valid) begin
            b_nots          <= s_descr_data[DW-1];
            b_ts            <= s_descr_data[DW-2 -: TW];
            m_burst_samples <= s_descr_data[WW +: SAMPLES_WIDTH];
            b_words         <= s_descr_data[WW-1:0];
            reads_left      <= s_descr_data[WW-1:0];
            beats_left      <= s_descr_data[WW-1:0];
            s_descr_ready   <= 1'b0;
            state           <= WAIT_TS;
          end else begin
            s_descr_ready <= 1'b1;
          end
        end
        WAIT_TS: begin
          if (b_words == '0) begin
            m_proc_idx_valid <= 1'b1;
            state            <= DONE;
          end else if (b_nots || (ts_diff == '0)) begin
            state <= PLAY;
          end else if (ts_diff[TW-1]) begin
            // Late burst: skip its samples so the RAM read pointer stays aligned.
            rd_ptr           <= rd_ptr + b_words;
            m_proc_idx_valid <= 1'b1;
            if (stat_late_bursts != '1) stat_late_bursts <= stat_late_bursts + STAT_FE_WIDTH'(1);
            state            <= DONE;
          end
        end
        PLAY: begin
          if (m_ram_rden) begin
            rd_ptr     <= rd_ptr + WW'(1);
            reads_left <= reads_left - WW'(1);
            if (reads_left == WW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (beats_left == WW'(1))) begin
            m_proc_idx_valid <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (proc_hs) begin
            cons_ptr         <= cons_next;
            m_fedma_ram_addr <= cons_next[WW -: FW];
            m_proc_idx_valid <= 1'b0;
            m_burst_samples  <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
